// File: rtl/tt_um_jleugeri_ttt_token_buffer.sv
// Per-processor good/bad token accumulator with saturating adds and an in-order drain stream.
// Each entry is cleared as it is drained so the buffer is empty again for the next input stage.
module tt_um_jleugeri_ttt_token_buffer #(
   parameter int NUM_PROCESSORS  = 16,
   parameter int NEW_TOKENS_BITS = 8,
   parameter int ADDR_BITS       = $clog2(NUM_PROCESSORS)
) (
   input  logic                       clock_fast,
   input  logic                       reset,
   input  logic                       clear_i,
   input  logic                       acc_valid_i,
   output logic                       acc_ready_o,
   input  logic [ADDR_BITS-1:0]       acc_addr_i,
   input  logic [NEW_TOKENS_BITS-1:0] acc_good_i,
   input  logic [NEW_TOKENS_BITS-1:0] acc_bad_i,
   input  logic                       drain_start_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [ADDR_BITS-1:0]       out_addr_o,
   output logic [NEW_TOKENS_BITS-1:0] out_good_o,
   output logic [NEW_TOKENS_BITS-1:0] out_bad_o,
   output logic                       out_last_o,
   output logic                       done_o,
   output logic                       sat_o
);

   localparam int B = NEW_TOKENS_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_PROCESSORS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic [B-1:0]         good_q [NUM_PROCESSORS];
   logic [B-1:0]         good_d [NUM_PROCESSORS];
   logic [B-1:0]         bad_q  [NUM_PROCESSORS];
   logic [B-1:0]         bad_d  [NUM_PROCESSORS];
   logic                 sat_q, sat_d;
   logic                 done_q, done_d;
   logic [B:0]           g_sum, b_sum;

   // Returns {clamped, result}; overflow shows up as the two top bits of the widened sum differing.
   function automatic logic [B:0] sat_add(input logic [B-1:0] a, input logic [B-1:0] b);
      logic [B:0] sum;
      sum = {a[B-1], a} + {b[B-1], b};
      if (sum[B] != sum[B-1]) begin
         return {1'b1, sum[B], {(B-1){~sum[B]}}};
      end
      return {1'b0, sum[B-1:0]};
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      good_d  = good_q;
      bad_d   = bad_q;
      g_sum   = '0;
      b_sum   = '0;
      case (state_q)
         IDLE: begin
            if (clear_i) begin
               for (int i = 0; i < NUM_PROCESSORS; i++) begin
                  good_d[i] = '0;
                  bad_d[i]  = '0;
               end
               sat_d = 1'b0;
            end
            // Accumulate on top of the (possibly just cleared) entry; out-of-range addresses match nothing.
            if (acc_valid_i) begin
               for (int i = 0; i < NUM_PROCESSORS; i++) begin
                  if (acc_addr_i == ADDR_BITS'(i)) begin
                     g_sum     = sat_add(good_d[i], acc_good_i);
                     b_sum     = sat_add(bad_d[i], acc_bad_i);
                     good_d[i] = g_sum[B-1:0];
                     bad_d[i]  = b_sum[B-1:0];
                     sat_d     = sat_d | g_sum[B] | b_sum[B];
                  end
               end
            end
            if (drain_start_i) begin
               state_d = DRAIN;
               idx_d   = '0;
            end
         end
         DRAIN: begin
            if (clear_i) begin
               for (int i = 0; i < NUM_PROCESSORS; i++) begin
                  good_d[i] = '0;
                  bad_d[i]  = '0;
               end
               sat_d   = 1'b0;
               state_d = IDLE;
               idx_d   = '0;
            end else if (out_ready_i) begin
               for (int i = 0; i < NUM_PROCESSORS; i++) begin
                  if (idx_q == ADDR_BITS'(i)) begin
                     good_d[i] = '0;
                     bad_d[i]  = '0;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_fast) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            good_q[i] <= '0;
            bad_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
      end
   end

   // Output stream is a pure decode of registered state, forced to zero outside DRAIN.
   always_comb begin
      out_valid_o = 1'b0;
      out_addr_o  = '0;
      out_good_o  = '0;
      out_bad_o   = '0;
      out_last_o  = 1'b0;
      if (state_q == DRAIN) begin
         out_valid_o = 1'b1;
         out_addr_o  = idx_q;
         out_last_o  = (idx_q == LAST_IDX);
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if (idx_q == ADDR_BITS'(i)) begin
               out_good_o = good_q[i];
               out_bad_o  = bad_q[i];
            end
         end
      end
   end

   assign acc_ready_o = (state_q == IDLE);
   assign done_o      = done_q;
   assign sat_o       = sat_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_buffer.sv
// Directed bench for the token buffer: a 4-entry instance for most scenarios and a
// 3-entry instance for the out-of-range address case.
module tb_tt_um_jleugeri_ttt_token_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic              reset, clear_i, acc_valid_i, drain_start_i, out_ready_i;
   logic [1:0]        acc_addr_i;
   logic signed [7:0] acc_good_i, acc_bad_i;
   logic              acc_ready_o, out_valid_o, out_last_o, done_o, sat_o;
   logic [1:0]        out_addr_o;
   logic [7:0]        out_good_o, out_bad_o;

   logic              clear3, valid3, drain3, ready3;
   logic [1:0]        addr3;
   logic signed [7:0] good3, bad3;
   logic              acc_ready3, out_valid3, out_last3, done3, sat3;
   logic [1:0]        out_addr3;
   logic [7:0]        out_good3, out_bad3;

   tt_um_jleugeri_ttt_token_buffer #(.NUM_PROCESSORS(4), .NEW_TOKENS_BITS(8)) dut (
      .clock_fast(clk), .reset(reset), .clear_i(clear_i),
      .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_addr_i(acc_addr_i),
      .acc_good_i(acc_good_i), .acc_bad_i(acc_bad_i), .drain_start_i(drain_start_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
      .out_good_o(out_good_o), .out_bad_o(out_bad_o), .out_last_o(out_last_o),
      .done_o(done_o), .sat_o(sat_o)
   );

   tt_um_jleugeri_ttt_token_buffer #(.NUM_PROCESSORS(3), .NEW_TOKENS_BITS(8)) dut3 (
      .clock_fast(clk), .reset(reset), .clear_i(clear3),
      .acc_valid_i(valid3), .acc_ready_o(acc_ready3), .acc_addr_i(addr3),
      .acc_good_i(good3), .acc_bad_i(bad3), .drain_start_i(drain3),
      .out_valid_o(out_valid3), .out_ready_i(ready3), .out_addr_o(out_addr3),
      .out_good_o(out_good3), .out_bad_o(out_bad3), .out_last_o(out_last3),
      .done_o(done3), .sat_o(sat3)
   );

   // Observation vector: {valid, addr, good, bad, last, done, acc_ready, sat}
   logic [22:0] obs, obs3;
   assign obs  = {out_valid_o, out_addr_o, out_good_o, out_bad_o, out_last_o, done_o, acc_ready_o, sat_o};
   assign obs3 = {out_valid3, out_addr3, out_good3, out_bad3, out_last3, done3, acc_ready3, sat3};

   function automatic logic [22:0] pack(input logic v, input logic [1:0] a, input logic [7:0] g,
                                        input logic [7:0] b, input logic last, input logic done,
                                        input logic rdy, input logic sat);
      return {v, a, g, b, last, done, rdy, sat};
   endfunction

   task automatic acc(input logic [1:0] a, input logic signed [7:0] g, input logic signed [7:0] b);
      acc_valid_i = 1'b1;
      acc_addr_i  = a;
      acc_good_i  = g;
      acc_bad_i   = b;
      @(negedge clk);
      acc_valid_i = 1'b0;
   endtask

   task automatic start_drain;
      drain_start_i = 1'b1;
      out_ready_i   = 1'b1;
      @(negedge clk);
      drain_start_i = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 1, 0));
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL post_reset: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 1, 0));
      end
   endtask

   task automatic test_accumulate;
      logic [7:0] eg [4];
      logic [7:0] eb [4];
      logic [22:0] e;
      eg = '{8'hFF, 8'h00, 8'h0C, 8'h00};
      eb = '{8'h00, 8'h00, 8'hFE, 8'h00};
      acc(2'd2, 8'sd5, -8'sd3);
      acc(2'd2, 8'sd7, 8'sd1);
      acc(2'd0, -8'sd1, 8'sd0);
      start_drain();
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), eg[i], eb[i], i == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL acc_drain[%0d]: got %h expected %h", i, obs, e);
         end
         @(negedge clk);
      end
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 1, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL acc_done: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 1, 1, 0));
      end
      @(negedge clk);
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL acc_done_once: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 1, 0));
      end
      start_drain();
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), 0, 0, i == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL acc_redrain[%0d]: got %h expected %h", i, obs, e);
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation;
      logic [22:0] e;
      repeat (3) acc(2'd1, 8'sd100, 8'sd0);
      repeat (2) acc(2'd1, 8'sd0, -8'sd100);
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 1)) begin
         n_fail++;
         $display("[TB] FAIL sat_flag: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 1, 1));
      end
      start_drain();
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), (i == 1) ? 8'h7F : 8'h00, (i == 1) ? 8'h80 : 8'h00, i == 3, 0, 0, 1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL sat_drain[%0d]: got %h expected %h", i, obs, e);
         end
         @(negedge clk);
      end
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 1, 1, 1)) begin
         n_fail++;
         $display("[TB] FAIL sat_sticky_done: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 1, 1, 1));
      end
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL sat_cleared: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 0, 1, 0));
      end
   endtask

   task automatic test_backpressure;
      bit pat [7];
      int idx;
      logic [22:0] e;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) acc(2'(i), 8'(i + 1), 8'(i + 1));
      drain_start_i = 1'b1;
      out_ready_i   = 1'b0;
      @(negedge clk);
      drain_start_i = 1'b0;
      idx = 0;
      for (int k = 0; k < 7; k++) begin
         e = pack(1, 2'(idx), 8'(idx + 1), 8'(idx + 1), idx == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL bp_step[%0d]: got %h expected %h", k, obs, e);
         end
         out_ready_i = pat[k];
         @(negedge clk);
         if (pat[k]) idx++;
      end
      n_checks++;
      if (obs !== pack(0, 0, 0, 0, 0, 1, 1, 0)) begin
         n_fail++;
         $display("[TB] FAIL bp_done: got %h expected %h", obs, pack(0, 0, 0, 0, 0, 1, 1, 0));
      end
      out_ready_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_simultaneous;
      logic [22:0] e;
      acc(2'd1, 8'sd9, 8'sd9);
      clear_i = 1'b1;
      acc(2'd3, 8'sd4, 8'sd4);
      clear_i = 1'b0;
      start_drain();
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), (i == 3) ? 8'h04 : 8'h00, (i == 3) ? 8'h04 : 8'h00, i == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL clear_acc[%0d]: got %h expected %h", i, obs, e);
         end
         @(negedge clk);
      end
      @(negedge clk);
      drain_start_i = 1'b1;
      out_ready_i   = 1'b1;
      acc(2'd0, 8'sd2, 8'sd0);
      drain_start_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), (i == 0) ? 8'h02 : 8'h00, 8'h00, i == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL drain_acc[%0d]: got %h expected %h", i, obs, e);
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_abort(input bit use_reset);
      string nm;
      logic [22:0] e;
      nm = use_reset ? "rst" : "clr";
      for (int i = 0; i < 4; i++) acc(2'(i), 8'sd5, 8'sd6);
      start_drain();
      for (int i = 0; i < 2; i++) begin
         e = pack(1, 2'(i), 8'h05, 8'h06, 0, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL abort_%s_pre[%0d]: got %h expected %h", nm, i, obs, e);
         end
         @(negedge clk);
      end
      if (use_reset) reset = 1'b1;
      else clear_i = 1'b1;
      out_ready_i = 1'b0;
      @(negedge clk);
      reset   = 1'b0;
      clear_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (obs !== pack(0, 0, 0, 0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("[TB] FAIL abort_%s_idle[%0d]: got %h expected %h", nm, k, obs, pack(0, 0, 0, 0, 0, 0, 1, 0));
         end
         @(negedge clk);
      end
      start_drain();
      for (int i = 0; i < 4; i++) begin
         e = pack(1, 2'(i), 0, 0, i == 3, 0, 0, 0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL abort_%s_redrain[%0d]: got %h expected %h", nm, i, obs, e);
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_out_of_range;
      logic [22:0] e;
      valid3 = 1'b1;
      addr3  = 2'd1;
      good3  = 8'sd127;
      bad3   = 8'sd0;
      @(negedge clk);
      good3 = 8'sd1;
      @(negedge clk);
      addr3 = 2'd3;
      good3 = -8'sd100;
      bad3  = -8'sd100;
      n_checks++;
      if (obs3 !== pack(0, 0, 0, 0, 0, 0, 1, 1)) begin
         n_fail++;
         $display("[TB] FAIL oor_pre: got %h expected %h", obs3, pack(0, 0, 0, 0, 0, 0, 1, 1));
      end
      @(negedge clk);
      valid3 = 1'b0;
      n_checks++;
      if (obs3 !== pack(0, 0, 0, 0, 0, 0, 1, 1)) begin
         n_fail++;
         $display("[TB] FAIL oor_sat_unchanged: got %h expected %h", obs3, pack(0, 0, 0, 0, 0, 0, 1, 1));
      end
      drain3 = 1'b1;
      ready3 = 1'b1;
      @(negedge clk);
      drain3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = pack(1, 2'(i), (i == 1) ? 8'h7F : 8'h00, 8'h00, i == 2, 0, 0, 1);
         n_checks++;
         if (obs3 !== e) begin
            n_fail++;
            $display("[TB] FAIL oor_drain[%0d]: got %h expected %h", i, obs3, e);
         end
         @(negedge clk);
      end
      n_checks++;
      if (obs3 !== pack(0, 0, 0, 0, 0, 1, 1, 1)) begin
         n_fail++;
         $display("[TB] FAIL oor_done: got %h expected %h", obs3, pack(0, 0, 0, 0, 0, 1, 1, 1));
      end
   endtask

   initial begin
      reset         = 1'b1;
      clear_i       = 1'b0;
      acc_valid_i   = 1'b0;
      acc_addr_i    = '0;
      acc_good_i    = '0;
      acc_bad_i     = '0;
      drain_start_i = 1'b0;
      out_ready_i   = 1'b0;
      clear3        = 1'b0;
      valid3        = 1'b0;
      addr3         = '0;
      good3         = '0;
      bad3          = '0;
      drain3        = 1'b0;
      ready3        = 1'b0;
      $display("[TB] starting token buffer bench");
      test_reset();
      test_accumulate();
      test_saturation();
      test_backpressure();
      test_simultaneous();
      test_out_of_range();
      test_abort(1'b0);
      test_abort(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
